// File: rtl/fp16_sub_seq.sv
// Sequential fp16 subtractor (A - B): bit-serial alignment and normalization
// under a five-state FSM, with valid/ready handshakes on both sides.
module fp16_sub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [4:0]  exp_q, exp_d;
    logic [11:0] mantL_q, mantL_d;
    logic [11:0] mantS_q, mantS_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;

    logic [4:0]  expA, expB, expDiff;
    logic [11:0] mantA, mantB;
    logic        signB, aBig, special;

    // Operand decode: B's sign is inverted so the datapath only ever adds
    // or subtracts magnitudes; ties in magnitude keep A as the larger.
    assign expA    = in_a[14:10];
    assign expB    = in_b[14:10];
    assign mantA   = (expA == 5'd0) ? 12'd0 : {2'b01, in_a[9:0]};
    assign mantB   = (expB == 5'd0) ? 12'd0 : {2'b01, in_b[9:0]};
    assign signB   = ~in_b[15];
    assign aBig    = (in_a[14:0] >= in_b[14:0]);
    assign expDiff = aBig ? (expA - expB) : (expB - expA);
    assign special = (expA == 5'h1F) || (expB == 5'h1F);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= 5'd0;
            mantL_q <= 12'd0;
            mantS_q <= 12'd0;
            cnt_q   <= 4'd0;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            mantL_q <= mantL_d;
            mantS_q <= mantS_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        mantL_d = mantL_q;
        mantS_d = mantS_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (special) begin
                        res_d   = 16'h7E00;
                        state_d = DONE;
                    end else begin
                        sub_d   = in_a[15] ^ signB;
                        sign_d  = (in_a[15] ^ signB) ? (aBig ? in_a[15] : signB) : in_a[15];
                        exp_d   = aBig ? expA : expB;
                        mantL_d = aBig ? mantA : mantB;
                        mantS_d = aBig ? mantB : mantA;
                        cnt_d   = (expDiff > 5'd12) ? 4'd12 : expDiff[3:0];
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ADD;
                end else begin
                    mantS_d = mantS_q >> 1;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ADD: begin
                mantL_d = sub_q ? (mantL_q - mantS_q) : (mantL_q + mantS_q);
                state_d = NORM;
            end
            NORM: begin
                if (mantL_q == 12'd0) begin
                    res_d   = 16'h0000;
                    state_d = DONE;
                end else if (mantL_q[11]) begin
                    mantL_d = mantL_q >> 1;
                    exp_d   = exp_q + 5'd1;
                    if (exp_q == 5'd30) begin
                        res_d   = {sign_q, 5'h1F, 10'h000};
                        state_d = DONE;
                    end
                end else if (mantL_q[10]) begin
                    res_d   = {sign_q, exp_q, mantL_q[9:0]};
                    state_d = DONE;
                end else begin
                    // Left shift cannot lose bits: bit11 is known clear here.
                    mantL_d = mantL_q << 1;
                    exp_d   = exp_q - 5'd1;
                    if (exp_q == 5'd1) begin
                        res_d   = {sign_q, 15'h0000};
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = res_q;
    end

endmodule

// File: tb/tb_fp16_sub_seq.sv
// Self-checking bench for fp16_sub_seq: directed cases, randomized operands
// against an integer reference model, backpressure and mid-operation reset.
module tb_fp16_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int passCount  = 0;
    int totalCount = 0;

    fp16_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference: align with one truncating shift, do integer add/subtract,
    // then normalize. Latency is counted in clock edges after the accept
    // edge: one per ALIGN cycle (d shifts plus the exit), one for ADD, one per
    // NORM cycle. A special result is visible right after the accept edge.
    function automatic void refModel(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] r, output int lat);
        int   ea, eb, ma, mb, eL, eS, mL, mS, d, mag, e, normCyc;
        logic sb, sL, sg, sub;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 31 || eb == 31) begin
            r   = 16'h7E00;
            lat = 0;
            return;
        end
        ma  = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
        mb  = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
        sb  = ~b[15];
        sub = (a[15] != sb);
        if (a[14:0] >= b[14:0]) begin
            eL = ea; mL = ma; eS = eb; mS = mb; sL = a[15];
        end else begin
            eL = eb; mL = mb; eS = ea; mS = ma; sL = sb;
        end
        sg = sub ? sL : a[15];
        d  = eL - eS;
        if (d > 12) d = 12;
        mag = sub ? (mL - (mS >> d)) : (mL + (mS >> d));
        e   = eL;
        normCyc = 1;
        if (mag == 0) begin
            r = 16'h0000;
        end else if (mag >= 2048) begin
            mag = mag >> 1;
            e   = e + 1;
            if (e == 31) begin
                r = {sg, 5'h1F, 10'h000};
            end else begin
                normCyc = 2;
                r = {sg, e[4:0], mag[9:0]};
            end
        end else begin
            normCyc = 0;
            r = 16'h0000;
            while (1) begin
                normCyc = normCyc + 1;
                if (mag >= 1024) begin
                    r = {sg, e[4:0], mag[9:0]};
                    break;
                end
                mag = mag << 1;
                e   = e - 1;
                if (e == 0) begin
                    r = {sg, 15'h0000};
                    break;
                end
            end
        end
        lat = d + 2 + normCyc;
    endfunction

    // Drives one operand pair, scrambles the inputs after acceptance, and
    // counts edges until out_valid (-1 if it never comes).
    task automatic doOp(input logic [15:0] a, input logic [15:0] b, input bit consume,
                        output logic [15:0] res, output int lat);
        int waitCnt;
        @(negedge clk);
        waitCnt = 0;
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out_data;
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        totalCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else passCount++;
        totalCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else passCount++;
        totalCount++;
        if (out_data !== 16'h0000) $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data);
        else passCount++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] opA [7] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h3C00};
        logic [15:0] opB [7] = '{16'h3C00, 16'h3C00, 16'h4000, 16'hBC00, 16'hFBFF, 16'h3C00, 16'h0000};
        logic [15:0] expR[7] = '{16'h0000, 16'h3C00, 16'hBC00, 16'h4000, 16'h7C00, 16'h7E00, 16'h3C00};
        int          expL[7] = '{3, 5, 5, 4, 3, 0, 15};
        logic [15:0] res;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            doOp(opA[i], opB[i], 1'b1, res, lat);
            totalCount++;
            if (res !== expR[i])
                $display("[TB] FAIL directed_data %h-%h: got %h expected %h", opA[i], opB[i], res, expR[i]);
            else passCount++;
            totalCount++;
            if (lat !== expL[i])
                $display("[TB] FAIL directed_latency %h-%h: got %0d expected %0d", opA[i], opB[i], lat, expL[i]);
            else passCount++;
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, tmp, res, expRes;
        int          lat, expLat;
        for (int i = 0; i < 60; i++) begin
            a   = 16'($urandom);
            tmp = 16'($urandom);
            // Half the pairs share an exponent to exercise cancellation.
            b   = (i % 2 == 0) ? {tmp[15], a[14:10], tmp[9:0]} : tmp;
            refModel(a, b, expRes, expLat);
            doOp(a, b, 1'b1, res, lat);
            totalCount++;
            if (res !== expRes)
                $display("[TB] FAIL random_data %h-%h: got %h expected %h", a, b, res, expRes);
            else passCount++;
            totalCount++;
            if (lat !== expLat)
                $display("[TB] FAIL random_latency %h-%h: got %0d expected %0d", a, b, lat, expLat);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] res;
        int          lat;
        doOp(16'h4000, 16'h3C00, 1'b0, res, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            totalCount++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h3C00)
                $display("[TB] FAIL backpressure_hold cycle %0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=3c00",
                         i, out_valid, in_ready, out_data);
            else passCount++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        totalCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL backpressure_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        else passCount++;
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] res;
        int          lat;
        bit          sawValid;
        @(negedge clk);
        in_a     = 16'h4000;
        in_b     = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        totalCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000)
            $display("[TB] FAIL midreset_state: got ready=%b valid=%b data=%h expected ready=1 valid=0 data=0000",
                     in_ready, out_valid, out_data);
        else passCount++;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        totalCount++;
        if (sawValid !== 1'b0) $display("[TB] FAIL midreset_no_pulse: got out_valid pulse expected none");
        else passCount++;
        doOp(16'h3C00, 16'hBC00, 1'b1, res, lat);
        totalCount++;
        if (res !== 16'h4000 || lat !== 4)
            $display("[TB] FAIL midreset_followup: got %h lat %0d expected 4000 lat 4", res, lat);
        else passCount++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
